// File: rtl/urv_pipe_ctrl_pkg.sv
// Shared constants for the uRV pipeline control unit: stage indices,
// legacy self-stall mask and a counter sizing helper.
package urv_pipe_ctrl_pkg;

  localparam int URV_STAGE_F = 0;
  localparam int URV_STAGE_D = 1;
  localparam int URV_STAGE_X = 2;
  localparam int URV_STAGE_W = 3;

  localparam logic [3:0] URV_SELF_STALL_MASK = 4'b1100;

  // Bits needed to hold max_val; never less than one.
  function automatic int urv_cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/urv_pipe_ctrl_if.sv
// Bundle between the stage modules / CSR block (master) and the pipeline
// control unit (slave).
interface urv_pipe_ctrl_if #(
  parameter int g_num_stages = 4,
  parameter int g_cnt_width  = 32
);
  // No valid/ready pairs here: branch_i, flush_i and the two clear inputs are
  // single-cycle pulses sampled every clock; stall_o/kill_o are level outputs
  // valid in the same cycle as the requests that produced them.
  logic [g_num_stages-1:0] stall_req_i;
  logic                    branch_i;
  logic                    flush_i;
  logic                    wdog_clr_i;
  logic                    cnt_clr_i;
  logic [g_num_stages-1:0] stall_o;
  logic [g_num_stages-1:0] kill_o;
  logic                    wdog_o;
  logic [g_cnt_width-1:0]  cnt_stall_o;
  logic [g_cnt_width-1:0]  cnt_kill_o;

  modport master (
    output stall_req_i, branch_i, flush_i, wdog_clr_i, cnt_clr_i,
    input  stall_o, kill_o, wdog_o, cnt_stall_o, cnt_kill_o
  );

  modport slave (
    input  stall_req_i, branch_i, flush_i, wdog_clr_i, cnt_clr_i,
    output stall_o, kill_o, wdog_o, cnt_stall_o, cnt_kill_o
  );
endinterface

// File: rtl/urv_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// the count sticks at all-ones instead of wrapping.
module urv_sat_counter #(
  parameter int g_width = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [g_width-1:0] cnt_o
);
  logic [g_width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/urv_pipe_ctrl.sv
// Pipeline control: merges stall requests into per-stage stall enables,
// builds branch/flush kill shadows, stall watchdog and perf counters.
module urv_pipe_ctrl
  import urv_pipe_ctrl_pkg::*;
#(
  parameter int                      g_num_stages      = 4,
  parameter int                      g_branch_stage    = 2,
  parameter logic [g_num_stages-1:0] g_self_stall_mask = g_num_stages'(URV_SELF_STALL_MASK),
  parameter int                      g_stall_timeout   = 1024,
  parameter int                      g_cnt_width       = 32
) (
  input logic            clk_i,
  input logic            rst_n_i,
  urv_pipe_ctrl_if.slave ctrl_if
);
  localparam int NS        = g_num_stages;
  localparam int BS        = g_branch_stage;
  localparam int FLUSH_LEN = NS - 2;
  localparam int FW        = urv_cnt_bits(FLUSH_LEN);
  localparam int WW        = urv_cnt_bits(g_stall_timeout);

  logic [NS-1:0] stall, kill;
  logic          req_above, br_acc, br_eff, flush_act;
  logic [BS-1:0] sh_q, sh_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          wdog_q, wdog_d, wdog_hit;

  // A stage stalls when any younger-to-older stage further down the pipe asks.
  always_comb begin
    stall     = '0;
    req_above = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      stall[i]  = req_above | (g_self_stall_mask[i] & ctrl_if.stall_req_i[i]);
      req_above = req_above | ctrl_if.stall_req_i[i];
    end
  end

  // A flush in the same cycle swallows the branch.
  assign br_eff    = ctrl_if.branch_i & ~ctrl_if.flush_i;
  assign flush_act = ctrl_if.flush_i | (flush_cnt_q != '0);

  always_comb begin
    kill   = '0;
    br_acc = br_eff;
    for (int i = 1; i <= BS; i++) begin
      br_acc  = br_acc | sh_q[i-1];
      kill[i] = br_acc;
    end
    for (int i = 1; i <= NS - 2; i++) begin
      kill[i] = kill[i] | flush_act;
    end
  end

  always_comb begin
    sh_d        = sh_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl_if.flush_i) begin
      sh_d        = '0;
      flush_cnt_d = FW'(FLUSH_LEN);
    end else begin
      if (!stall[BS]) begin
        sh_d[0] = ctrl_if.branch_i;
        for (int k = 1; k < BS; k++) begin
          sh_d[k] = sh_q[k-1];
        end
      end
      if ((flush_cnt_q != '0) && !stall[NS-2]) begin
        flush_cnt_d = flush_cnt_q - 1'b1;
      end
    end
  end

  generate
    if (g_stall_timeout > 0) begin : g_wdog
      logic [WW-1:0] wdog_cnt;
      urv_sat_counter #(.g_width(WW)) u_wdog_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (~stall[0] | ctrl_if.wdog_clr_i),
        .inc_i   (stall[0]),
        .cnt_o   (wdog_cnt)
      );
      // Fires at the edge that completes the timeout-th stalled cycle.
      assign wdog_hit = stall[0] & (wdog_cnt >= WW'(g_stall_timeout - 1));
    end else begin : g_no_wdog
      assign wdog_hit = 1'b0;
    end
  endgenerate

  assign wdog_d = ctrl_if.wdog_clr_i ? 1'b0 : (wdog_q | wdog_hit);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sh_q        <= '0;
      flush_cnt_q <= '0;
      wdog_q      <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      flush_cnt_q <= flush_cnt_d;
      wdog_q      <= wdog_d;
    end
  end

  urv_sat_counter #(.g_width(g_cnt_width)) u_cnt_stall (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (ctrl_if.cnt_clr_i),
    .inc_i   (|stall),
    .cnt_o   (ctrl_if.cnt_stall_o)
  );

  urv_sat_counter #(.g_width(g_cnt_width)) u_cnt_kill (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (ctrl_if.cnt_clr_i),
    .inc_i   (ctrl_if.branch_i | ctrl_if.flush_i),
    .cnt_o   (ctrl_if.cnt_kill_o)
  );

  assign ctrl_if.stall_o = stall;
  assign ctrl_if.kill_o  = kill;
  assign ctrl_if.wdog_o  = wdog_q;
endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Directed bench for urv_pipe_ctrl: a 4-stage unit (short watchdog, 4-bit
// counters) and a 6-stage unit with the branch resolving in stage 3.
module tb_urv_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  urv_pipe_ctrl_if #(.g_num_stages(4), .g_cnt_width(4))  if_a ();
  urv_pipe_ctrl_if #(.g_num_stages(6), .g_cnt_width(32)) if_b ();

  urv_pipe_ctrl #(
    .g_num_stages(4), .g_branch_stage(2), .g_self_stall_mask(4'b1100),
    .g_stall_timeout(8), .g_cnt_width(4)
  ) u_dut_a (.clk_i(clk), .rst_n_i(rst_n), .ctrl_if(if_a));

  urv_pipe_ctrl #(
    .g_num_stages(6), .g_branch_stage(3), .g_self_stall_mask(6'b001100),
    .g_stall_timeout(1024), .g_cnt_width(32)
  ) u_dut_b (.clk_i(clk), .rst_n_i(rst_n), .ctrl_if(if_b));

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    check(tag, obs);
  endtask

  task automatic step_a(input logic [3:0] req, input logic br, input logic fl,
                        input logic wc, input logic cc,
                        input logic [3:0] ek, input logic [3:0] es);
    @(negedge clk);
    if_a.stall_req_i = req;
    if_a.branch_i    = br;
    if_a.flush_i     = fl;
    if_a.wdog_clr_i  = wc;
    if_a.cnt_clr_i   = cc;
    exp_q.push_back(32'(ek));
    exp_q.push_back(32'(es));
    #1;
    check("a_kill", 32'(if_a.kill_o));
    check("a_stall", 32'(if_a.stall_o));
  endtask

  task automatic step_b(input logic rst, input logic [5:0] req, input logic br,
                        input logic fl, input logic [5:0] ek, input logic [5:0] es);
    @(negedge clk);
    rst_n            = rst;
    if_b.stall_req_i = req;
    if_b.branch_i    = br;
    if_b.flush_i     = fl;
    exp_q.push_back(32'(ek));
    exp_q.push_back(32'(es));
    #1;
    check("b_kill", 32'(if_b.kill_o));
    check("b_stall", 32'(if_b.stall_o));
  endtask

  initial begin
    if_a.stall_req_i = '0; if_a.branch_i = 1'b0; if_a.flush_i = 1'b0;
    if_a.wdog_clr_i = 1'b0; if_a.cnt_clr_i = 1'b0;
    if_b.stall_req_i = '0; if_b.branch_i = 1'b0; if_b.flush_i = 1'b0;
    if_b.wdog_clr_i = 1'b0; if_b.cnt_clr_i = 1'b0;

    // Reset: outputs follow inputs only, registers read zero.
    repeat (2) @(negedge clk);
    step_a(4'h0, 1, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_rst_wdog", 32'(if_a.wdog_o), 0);
    expect_now("a_rst_cnt_stall", 32'(if_a.cnt_stall_o), 0);
    expect_now("a_rst_cnt_kill", 32'(if_a.cnt_kill_o), 0);
    expect_now("b_rst_kill", 32'(if_b.kill_o), 0);
    rst_n = 1'b1;

    // Branch, no stalls.
    step_a(4'h0, 1, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0100, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_cnt_kill_br", 32'(if_a.cnt_kill_o), 1);
    expect_now("a_cnt_stall_br", 32'(if_a.cnt_stall_o), 0);

    // Branch, then writeback stall holds the shadow.
    step_a(4'h0, 1, 0, 0, 0, 4'b0110, 4'b0000);
    repeat (3) step_a(4'b1000, 0, 0, 0, 0, 4'b0110, 4'b1111);
    step_a(4'h0, 0, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0100, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_cnt_kill_brst", 32'(if_a.cnt_kill_o), 2);
    expect_now("a_cnt_stall_brst", 32'(if_a.cnt_stall_o), 3);
    expect_now("a_wdog_short", 32'(if_a.wdog_o), 0);

    // Flush together with branch: flush wins, one count.
    step_a(4'h0, 1, 1, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_cnt_kill_fl", 32'(if_a.cnt_kill_o), 3);

    // Flush extension only counts non-stalled cycles of stage 2.
    step_a(4'h0, 0, 1, 0, 0, 4'b0110, 4'b0000);
    repeat (2) step_a(4'b0100, 0, 0, 0, 0, 4'b0110, 4'b0111);
    step_a(4'h0, 0, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0110, 4'b0000);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    step_a(4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0001);
    expect_now("a_cnt_kill_fl2", 32'(if_a.cnt_kill_o), 4);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_cnt_stall_fl2", 32'(if_a.cnt_stall_o), 6);

    // Watchdog: 7 stalled cycles must not fire, 8 must.
    repeat (7) step_a(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0111);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_wdog_7", 32'(if_a.wdog_o), 0);
    repeat (8) step_a(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0111);
    expect_now("a_wdog_in8", 32'(if_a.wdog_o), 0);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_wdog_rise", 32'(if_a.wdog_o), 1);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_wdog_sticky", 32'(if_a.wdog_o), 1);
    step_a(4'h0, 0, 0, 1, 0, 4'b0000, 4'b0000);
    expect_now("a_wdog_clr_cyc", 32'(if_a.wdog_o), 1);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_wdog_cleared", 32'(if_a.wdog_o), 0);
    expect_now("a_cnt_stall_sat", 32'(if_a.cnt_stall_o), 15);

    // Clear on a stalled cycle beats the increment.
    step_a(4'b0100, 0, 0, 0, 1, 4'b0000, 4'b0111);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_cnt_stall_clr", 32'(if_a.cnt_stall_o), 0);
    expect_now("a_cnt_kill_clr", 32'(if_a.cnt_kill_o), 0);
    step_a(4'b0100, 0, 0, 0, 0, 4'b0000, 4'b0111);
    step_a(4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
    expect_now("a_cnt_stall_one", 32'(if_a.cnt_stall_o), 1);

    // Six stages, branch resolving in stage 3.
    step_b(1, 6'h00, 1, 0, 6'b001110, 6'b000000);
    step_b(1, 6'h00, 0, 0, 6'b001110, 6'b000000);
    step_b(1, 6'h00, 0, 0, 6'b001100, 6'b000000);
    step_b(1, 6'h00, 0, 0, 6'b001000, 6'b000000);
    step_b(1, 6'h00, 0, 0, 6'b000000, 6'b000000);
    step_b(1, 6'h00, 0, 1, 6'b011110, 6'b000000);
    repeat (4) step_b(1, 6'h00, 0, 0, 6'b011110, 6'b000000);
    step_b(1, 6'h00, 0, 0, 6'b000000, 6'b000000);
    step_b(1, 6'b000100, 0, 0, 6'b000000, 6'b000111);
    step_b(1, 6'b100000, 0, 0, 6'b000000, 6'b011111);
    step_b(1, 6'h00, 0, 0, 6'b000000, 6'b000000);
    expect_now("b_cnt_stall", if_b.cnt_stall_o, 2);
    expect_now("b_cnt_kill", if_b.cnt_kill_o, 2);

    // Reset mid-shadow drops kill on the following cycle.
    step_b(1, 6'h00, 1, 0, 6'b001110, 6'b000000);
    step_b(0, 6'h00, 0, 0, 6'b001110, 6'b000000);
    step_b(0, 6'h00, 0, 0, 6'b000000, 6'b000000);
    expect_now("b_rst_cnt_kill", if_b.cnt_kill_o, 0);
    step_b(1, 6'h00, 0, 0, 6'b000000, 6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
